comm_host: RTL and testbench

- Host-side initiator for the single-letter UART command protocol that the on-FPGA comm controller answers.
- Accepts one command request at a time and emits the command byte through a UART transmitter.
- For write, streams the memory image out; for read, collects the 512-byte image into a local byte memory; checks ping/status replies.
- Used in the host bridge and as the protocol driver in system benches.

---
 rtl/comm_host.sv | 249 ++++++++++++++++++++++++
 tb/tb_comm_host.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_host.sv
// comm_host: host-side initiator for the single-letter UART command protocol.
// It takes one command request at a time and sends the command letter over the UART.
// A write command then streams the local memory image out. A read command collects
// the image into the local memory. Ping and status commands check a one-byte reply.
//
// Ports:
//   clk, rst_n            clock (posedge) and asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_op                0 ping, 1 read, 2 write, 3 execute, 4 status, 5-7 illegal
//   done/error            one-cycle completion pulse; error stays valid until the next done
//   status_run            last status reply ('+' = 1, '-' = 0)
//   rx_valid/rx_data      received byte strobe from the UART receiver
//   tx_start/tx_data      transmit request pulse and byte; tx_busy comes from the transmitter
//   mem_addr/mem_we/...   local image memory port (read data has 1-cycle latency)
module comm_host #(
  parameter int MEM_BYTES = 512,
  parameter int TIMEOUT   = 1000000,
  parameter int TW        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  output logic       done,
  output logic       error,
  output logic       status_run,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [8:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_TX_HOLD, S_TX_WAIT, S_FETCH, S_SEND_DATA, S_RECV, S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    OP_PING   = 3'd0,
    OP_READ   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_EXEC   = 3'd3,
    OP_STATUS = 3'd4
  } op_e;

  localparam logic [8:0]    LAST_ADDR = 9'(MEM_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic          payload_q, payload_d;   // 0 while the command letter is in flight
  logic [8:0]    rx_cnt_q, rx_cnt_d;     // next read-payload byte index
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          status_run_q, status_run_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [8:0]    mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    payload_d    = payload_q;
    rx_cnt_d     = rx_cnt_q;
    tmo_d        = tmo_q;
    done_d       = 1'b0;
    error_d      = error_q;
    status_run_d = status_run_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mem_addr_d = '0;
          rx_cnt_d   = '0;
          payload_d  = 1'b0;
          tmo_d      = '0;
          if (cmd_op > 3'd4) begin
            // done is registered, so it is visible on the cycle spent in FINISH
            state_d = S_FINISH;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            op_d    = op_e'(cmd_op);
            state_d = S_SEND_CMD;
          end
        end
      end

      S_SEND_CMD: begin
        unique case (op_q)
          OP_PING:   tx_data_d = 8'h70;
          OP_READ:   tx_data_d = 8'h72;
          OP_WRITE:  tx_data_d = 8'h77;
          OP_EXEC:   tx_data_d = 8'h78;
          default:   tx_data_d = 8'h73;
        endcase
        tx_start_d = 1'b1;
        state_d    = S_TX_HOLD;
      end

      // tx_busy only rises the cycle after tx_start, so one blind cycle is needed
      S_TX_HOLD: state_d = S_TX_WAIT;

      S_TX_WAIT: begin
        if (!tx_busy) begin
          if (!payload_q) begin
            unique case (op_q)
              OP_WRITE: begin
                state_d    = S_FETCH;
                mem_addr_d = '0;
              end
              OP_EXEC: begin
                state_d = S_FINISH;
                done_d  = 1'b1;
                error_d = 1'b0;
              end
              default: begin
                state_d = S_RECV;
                tmo_d   = '0;
              end
            endcase
          end else if (mem_addr_q == LAST_ADDR) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            error_d = 1'b0;
          end else begin
            mem_addr_d = mem_addr_q + 9'd1;
            state_d    = S_FETCH;
          end
        end
      end

      S_FETCH: state_d = S_SEND_DATA;

      S_SEND_DATA: begin
        tx_data_d  = mem_rdata;
        tx_start_d = 1'b1;
        payload_d  = 1'b1;
        state_d    = S_TX_HOLD;
      end

      S_RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout
        if (rx_valid) begin
          tmo_d = '0;
          unique case (op_q)
            OP_PING: begin
              state_d = S_FINISH;
              done_d  = 1'b1;
              error_d = (rx_data != 8'h50);
            end
            OP_STATUS: begin
              state_d = S_FINISH;
              done_d  = 1'b1;
              error_d = 1'b0;
              if (rx_data == 8'h2B)      status_run_d = 1'b1;
              else if (rx_data == 8'h2D) status_run_d = 1'b0;
              else                       error_d      = 1'b1;
            end
            OP_READ: begin
              // Separate byte counter keeps mem_addr aligned with mem_we even
              // when bytes arrive on consecutive cycles
              mem_we_d    = 1'b1;
              mem_wdata_d = rx_data;
              mem_addr_d  = rx_cnt_q;
              rx_cnt_d    = rx_cnt_q + 9'd1;
              if (rx_cnt_q == LAST_ADDR) begin
                state_d = S_FINISH;
                done_d  = 1'b1;
                error_d = 1'b0;
              end
            end
            default: begin
              state_d = S_FINISH;
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_PING;
      payload_q    <= 1'b0;
      rx_cnt_q     <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      status_run_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      payload_q    <= payload_d;
      rx_cnt_q     <= rx_cnt_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      error_q      <= error_d;
      status_run_q <= status_run_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign status_run = status_run_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_comm_host.sv
module tb_comm_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic       done, error, status_run;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [8:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comm_host #(.MEM_BYTES(512), .TIMEOUT(150), .TW(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .done(done), .error(error), .status_run(status_run),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous read, write on mem_we, bulk preload on request
  logic [7:0] mem [0:511];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (preload) begin
      for (int unsigned i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Transmitter model: busy for 10 cycles starting the cycle after tx_start
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start)          busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitors
  logic [7:0] txq[$];
  logic [8:0] waddr_q[$];
  logic [7:0] wdata_q[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (tx_start) txq.push_back(tx_data);
    if (mem_we) begin
      waddr_q.push_back(mem_addr);
      wdata_q.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  // Stimulus helpers; all start and end at a negedge
  task automatic issue_cmd(input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (cyc <= max_cyc) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (status_run !== 1'b0) begin errors++; $display("FAIL reset_status_run: got %b expected 0", status_run); end
    checks++; if (tx_start !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got tx_start=%b mem_we=%b expected 0/0", tx_start, mem_we); end
    checks++; if (tx_data !== 8'h00 || mem_addr !== 9'h000 || mem_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_data: got tx_data=%h mem_addr=%h mem_wdata=%h expected 0", tx_data, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ping();
    int base = txq.size();
    bit seen; int cyc;
    issue_cmd(3'd0);
    repeat (100) @(negedge clk);
    send_rx(8'h50);
    wait_done(2, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL ping_done: got no done within 2 cycles expected done"); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ping_error: got %b expected 0", error); end
    checks++; if (txq.size() - base != 1 || txq[base] !== 8'h70) begin
      errors++; $display("FAIL ping_tx: got %0d bytes first=%h expected 1 byte 70", txq.size() - base, txq[base]);
    end
    @(negedge clk);
  endtask

  task automatic test_status();
    logic [7:0] reply [3] = '{8'h2B, 8'h2D, 8'h41};
    logic       exp_run [3] = '{1'b1, 1'b0, 1'b0};
    logic       exp_err [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      int base = txq.size();
      issue_cmd(3'd4);
      repeat (30) @(negedge clk);
      send_rx(reply[k]);
      checks++; if (done !== 1'b1 || error !== exp_err[k]) begin
        errors++; $display("FAIL status_done_%0d: got done=%b error=%b expected 1/%b", k, done, error, exp_err[k]);
      end
      checks++; if (status_run !== exp_run[k]) begin
        errors++; $display("FAIL status_run_%0d: got %b expected %b", k, status_run, exp_run[k]);
      end
      checks++; if (txq.size() - base != 1 || txq[base] !== 8'h73) begin
        errors++; $display("FAIL status_tx_%0d: got %0d bytes first=%h expected 1 byte 73", k, txq.size() - base, txq[base]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_execute();
    int base = txq.size();
    bit seen; int cyc;
    issue_cmd(3'd3);
    wait_done(40, seen, cyc);
    checks++; if (!seen || error !== 1'b0) begin errors++; $display("FAIL exec_done: got seen=%b error=%b expected 1/0", seen, error); end
    checks++; if (txq.size() - base != 1 || txq[base] !== 8'h78) begin
      errors++; $display("FAIL exec_tx: got %0d bytes first=%h expected 1 byte 78", txq.size() - base, txq[base]);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int base = txq.size();
    issue_cmd(3'd6);
    checks++; if (done !== 1'b1 || error !== 1'b1) begin
      errors++; $display("FAIL illegal_done: got done=%b error=%b expected 1/1", done, error);
    end
    repeat (15) @(negedge clk);
    checks++; if (txq.size() != base) begin errors++; $display("FAIL illegal_tx: got %0d tx pulses expected 0", txq.size() - base); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write();
    int base = txq.size();
    int wbase = waddr_q.size();
    int bad = 0;
    bit seen; int cyc;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    issue_cmd(3'd2);
    wait_done(10000, seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL write_done: got no done in 10000 cycles expected done"); end
    checks++; if (error !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL write_error: got error=%b tx_busy=%b expected 0/0", error, tx_busy); end
    checks++; if (txq.size() - base != 513) begin errors++; $display("FAIL write_count: got %0d tx pulses expected 513", txq.size() - base); end
    checks++; if (txq[base] !== 8'h77) begin errors++; $display("FAIL write_cmd: got %h expected 77", txq[base]); end
    for (int i = 0; i < 512 && base + 1 + i < txq.size(); i++) begin
      if (txq[base + 1 + i] !== (8'(i) ^ 8'hA5)) begin
        if (bad == 0) $display("FAIL write_byte_%0d: got %h expected %h", i, txq[base + 1 + i], 8'(i) ^ 8'hA5);
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL write_payload: got %0d wrong bytes expected 0", bad); end
    checks++; if (waddr_q.size() != wbase) begin errors++; $display("FAIL write_mem_we: got %0d writes expected 0", waddr_q.size() - wbase); end
    @(negedge clk);
  endtask

  task automatic test_read();
    int wbase = waddr_q.size();
    int dc0 = done_cnt;
    int bad = 0;
    issue_cmd(3'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      send_rx(8'(i * 3));
      if (i % 2 == 1) @(negedge clk);  // mix back-to-back and spaced bytes
    end
    @(negedge clk);
    checks++; if (done_cnt != dc0 + 1 || error !== 1'b0) begin
      errors++; $display("FAIL read_done: got %0d done pulses error=%b expected 1/0", done_cnt - dc0, error);
    end
    checks++; if (waddr_q.size() - wbase != 512) begin errors++; $display("FAIL read_count: got %0d writes expected 512", waddr_q.size() - wbase); end
    for (int i = 0; i < 512 && wbase + i < waddr_q.size(); i++) begin
      if (waddr_q[wbase + i] !== 9'(i) || wdata_q[wbase + i] !== 8'(i * 3)) begin
        if (bad == 0) $display("FAIL read_write_%0d: got addr=%h data=%h expected %h/%h", i, waddr_q[wbase + i], wdata_q[wbase + i], 9'(i), 8'(i * 3));
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL read_payload: got %0d wrong writes expected 0", bad); end
    checks++; if (mem[511] !== 8'((511 * 3) & 255)) begin errors++; $display("FAIL read_mem_last: got %h expected %h", mem[511], 8'(511 * 3)); end
  endtask

  task automatic test_timeout_read();
    int wbase = waddr_q.size();
    int early = 0;
    issue_cmd(3'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10; i++) send_rx(8'h10 + 8'(i));
    for (int k = 1; k < 150; k++) begin
      @(negedge clk);
      if (done) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: got done %0d times before 150 cycles expected 0", early); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b1) begin
      errors++; $display("FAIL tmo_done: got done=%b error=%b at 150 cycles expected 1/1", done, error);
    end
    checks++; if (waddr_q.size() - wbase != 10) begin errors++; $display("FAIL tmo_writes: got %0d writes expected 10", waddr_q.size() - wbase); end
    checks++; if (waddr_q[wbase + 9] !== 9'd9 || wdata_q[wbase + 9] !== 8'h19) begin
      errors++; $display("FAIL tmo_last_write: got addr=%h data=%h expected 009/19", waddr_q[wbase + 9], wdata_q[wbase + 9]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout_ping();
    bit seen; int cyc;
    issue_cmd(3'd0);
    wait_done(300, seen, cyc);
    // 13 cycles to send the command letter plus 150 timeout cycles
    checks++; if (!seen || cyc != 163) begin errors++; $display("FAIL ping_tmo_time: got seen=%b cycle=%0d expected 1/163", seen, cyc); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ping_tmo_error: got %b expected 1", error); end
    @(negedge clk);
  endtask

  task automatic test_idle_rx();
    int wbase = waddr_q.size();
    int dc0 = done_cnt;
    send_rx(8'h50);
    repeat (3) @(negedge clk);
    checks++; if (waddr_q.size() != wbase || done_cnt != dc0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL idle_rx: got writes=%0d dones=%0d ready=%b expected 0/0/1", waddr_q.size() - wbase, done_cnt - dc0, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    int dc0, tx0;
    issue_cmd(3'd2);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got ready=%b done=%b error=%b tx_start=%b expected 1/0/0/0", cmd_ready, done, error, tx_start);
    end
    checks++; if (tx_data !== 8'h00 || mem_addr !== 9'h000) begin
      errors++; $display("FAIL rst_mid_data: got tx_data=%h mem_addr=%h expected 00/000", tx_data, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_cnt;
    tx0 = txq.size();
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != dc0 || txq.size() != tx0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_after: got dones=%0d tx=%0d ready=%b expected 0/0/1", done_cnt - dc0, txq.size() - tx0, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_status();
    test_execute();
    test_illegal();
    test_write();
    test_read();
    test_timeout_read();
    test_timeout_ping();
    test_idle_rx();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
